// File: rtl/mem_arbiter_if.sv
`timescale 1ns/1ps
// Bus bundle joining the fetch and load/store requesters, the arbiter and
// the single shared RAM port.
interface mem_arbiter_if;
  logic        if_req;
  logic [63:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        mem_req;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;
  logic        mem_valid;
  logic        ram_en;
  logic        ram_we;
  logic [9:0]  ram_addr;
  logic [63:0] ram_wdata;
  logic [63:0] ram_rdata;
  logic        stall_if;
  logic        stall_mem;

  // Arbiter side: takes requests and RAM read data, drives everything else.
  modport slave (
    input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, ram_rdata,
    output if_rdata, if_valid, mem_rdata, mem_valid,
           ram_en, ram_we, ram_addr, ram_wdata, stall_if, stall_mem
  );

  // Requester / RAM-model side.
  modport master (
    output if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, ram_rdata,
    input  if_rdata, if_valid, mem_rdata, mem_valid,
           ram_en, ram_we, ram_addr, ram_wdata, stall_if, stall_mem
  );
endinterface

// File: rtl/mem_arbiter.sv
`timescale 1ns/1ps
// Two-requester arbiter in front of a single-ported RAM. Load/store (MEM)
// normally wins over instruction fetch (IF); after STARVE_MAX consecutive MEM
// wins with IF waiting, IF is forced through. Each access occupies the RAM
// port for LATENCY cycles followed by one IDLE cycle carrying the valid pulse.
module mem_arbiter #(
  parameter int unsigned LATENCY    = 2,
  parameter int unsigned STARVE_MAX = 3
) (
  input logic          clk,
  input logic          reset,
  mem_arbiter_if.slave bus
);

  localparam int unsigned   SW         = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [2:0]    BUSY_INIT  = 3'(LATENCY - 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_BUSY_IF  = 2'd1,
    S_BUSY_MEM = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [SW-1:0] starve_cnt_q, starve_cnt_d;
  logic [2:0]    busy_cnt_q, busy_cnt_d;
  logic          ram_en_q, ram_en_d;
  logic          ram_we_q, ram_we_d;
  logic [9:0]    ram_addr_q, ram_addr_d;
  logic [63:0]   ram_wdata_q, ram_wdata_d;
  logic [31:0]   if_rdata_q, if_rdata_d;
  logic [63:0]   mem_rdata_q, mem_rdata_d;
  logic          if_valid_q, if_valid_d;
  logic          mem_valid_q, mem_valid_d;

  logic          grant_mem_s;
  logic          grant_if_s;
  logic          unused_addr_bits;

  // MEM wins any contest except when IF has already been passed over
  // STARVE_MAX times in a row.
  assign grant_mem_s = bus.mem_req & (~bus.if_req | (starve_cnt_q != STARVE_LIM));
  assign grant_if_s  = bus.if_req & ~grant_mem_s;

  // Only the low 10 address bits reach the RAM.
  assign unused_addr_bits = ^{bus.if_addr[63:10], bus.mem_addr[63:10]};

  assign bus.ram_en    = ram_en_q;
  assign bus.ram_we    = ram_we_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_wdata = ram_wdata_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.mem_rdata = mem_rdata_q;
  assign bus.if_valid  = if_valid_q;
  assign bus.mem_valid = mem_valid_q;
  assign bus.stall_if  = bus.if_req & ~if_valid_q;
  assign bus.stall_mem = bus.mem_req & ~mem_valid_q;

  // Next-state logic: grant in IDLE, count down in BUSY, capture on exit.
  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    busy_cnt_d   = busy_cnt_q;
    ram_en_d     = 1'b0;
    ram_we_d     = ram_we_q;
    ram_addr_d   = ram_addr_q;
    ram_wdata_d  = ram_wdata_q;
    if_rdata_d   = if_rdata_q;
    mem_rdata_d  = mem_rdata_q;
    if_valid_d   = 1'b0;
    mem_valid_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (grant_mem_s) begin
          state_d     = S_BUSY_MEM;
          busy_cnt_d  = BUSY_INIT;
          ram_en_d    = 1'b1;
          ram_we_d    = bus.mem_we;
          ram_addr_d  = bus.mem_addr[9:0];
          ram_wdata_d = bus.mem_wdata;
          if (bus.if_req && (starve_cnt_q != STARVE_LIM)) begin
            starve_cnt_d = starve_cnt_q + SW'(1);
          end else begin
            starve_cnt_d = starve_cnt_q;
          end
        end else if (grant_if_s) begin
          state_d      = S_BUSY_IF;
          busy_cnt_d   = BUSY_INIT;
          ram_en_d     = 1'b1;
          ram_we_d     = 1'b0;
          ram_addr_d   = bus.if_addr[9:0];
          ram_wdata_d  = 64'd0;
          starve_cnt_d = SW'(0);
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BUSY_IF, S_BUSY_MEM: begin
        if (busy_cnt_q == 3'd0) begin
          state_d  = S_IDLE;
          ram_we_d = 1'b0;
          if (state_q == S_BUSY_IF) begin
            if_valid_d = 1'b1;
            if_rdata_d = ram_addr_q[2] ? bus.ram_rdata[63:32] : bus.ram_rdata[31:0];
          end else begin
            mem_valid_d = 1'b1;
            if (!ram_we_q) begin
              mem_rdata_d = bus.ram_rdata;
            end else begin
              mem_rdata_d = mem_rdata_q;
            end
          end
        end else begin
          busy_cnt_d = busy_cnt_q - 3'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset clears everything and aborts any access.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      starve_cnt_q <= SW'(0);
      busy_cnt_q   <= 3'd0;
      ram_en_q     <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= 10'd0;
      ram_wdata_q  <= 64'd0;
      if_rdata_q   <= 32'd0;
      mem_rdata_q  <= 64'd0;
      if_valid_q   <= 1'b0;
      mem_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      busy_cnt_q   <= busy_cnt_d;
      ram_en_q     <= ram_en_d;
      ram_we_q     <= ram_we_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
      if_rdata_q   <= if_rdata_d;
      mem_rdata_q  <= mem_rdata_d;
      if_valid_q   <= if_valid_d;
      mem_valid_q  <= mem_valid_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized
// run against a transaction-level reference model (edge-index arithmetic).
module tb_mem_arbiter;

  localparam int LAT_A = 2;
  localparam int SMAX  = 3;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mem_arbiter_if bus_a();
  mem_arbiter_if bus_b();

  mem_arbiter #(.LATENCY(LAT_A), .STARVE_MAX(SMAX)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
  mem_arbiter #(.LATENCY(1),     .STARVE_MAX(SMAX)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

  // Reference model for dut_a: an access granted at edge e completes at e+LAT_A.
  int          edge_n;
  int          m_done;
  bit          m_active;
  bit          m_is_if;
  bit          m_we;
  logic [9:0]  m_addr;
  logic [63:0] m_wdata;
  int          m_starve;
  logic        exp_if_valid, exp_mem_valid, exp_ram_en, exp_ram_we;
  logic [31:0] exp_if_rdata;
  logic [63:0] exp_mem_rdata;

  task automatic model_reset();
    m_active = 1'b0; m_starve = 0; m_done = -1;
    exp_if_valid = 1'b0; exp_mem_valid = 1'b0; exp_ram_en = 1'b0; exp_ram_we = 1'b0;
    exp_if_rdata = 32'd0; exp_mem_rdata = 64'd0;
  endtask

  task automatic model_edge();
    exp_if_valid = 1'b0; exp_mem_valid = 1'b0; exp_ram_en = 1'b0;
    if (m_active && edge_n == m_done) begin
      m_active = 1'b0; exp_ram_we = 1'b0;
      if (m_is_if) begin
        exp_if_rdata = m_addr[2] ? bus_a.ram_rdata[63:32] : bus_a.ram_rdata[31:0];
        exp_if_valid = 1'b1;
      end else begin
        exp_mem_valid = 1'b1;
        if (!m_we) exp_mem_rdata = bus_a.ram_rdata;
      end
    end else if (!m_active && (bus_a.if_req || bus_a.mem_req)) begin
      m_is_if = bus_a.if_req && (!bus_a.mem_req || m_starve == SMAX);
      if (m_is_if) begin
        m_starve = 0; m_addr = bus_a.if_addr[9:0]; m_we = 1'b0; m_wdata = 64'd0;
      end else begin
        if (bus_a.if_req && m_starve < SMAX) m_starve++;
        m_addr = bus_a.mem_addr[9:0]; m_we = bus_a.mem_we; m_wdata = bus_a.mem_wdata;
      end
      m_active = 1'b1; m_done = edge_n + LAT_A;
      exp_ram_en = 1'b1; exp_ram_we = m_we;
    end
  endtask

  // Advance one clock; model follows the inputs present at the edge.
  task automatic cycle();
    @(posedge clk);
    if (!reset) model_reset(); else model_edge();
    edge_n++;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; edge_n = 0; model_reset();
    bus_a.if_req = 1'b0; bus_a.if_addr = 64'd0; bus_a.mem_req = 1'b0; bus_a.mem_we = 1'b0;
    bus_a.mem_addr = 64'd0; bus_a.mem_wdata = 64'd0; bus_a.ram_rdata = 64'd0;
    bus_b.if_req = 1'b0; bus_b.if_addr = 64'd0; bus_b.mem_req = 1'b0; bus_b.mem_we = 1'b0;
    bus_b.mem_addr = 64'd0; bus_b.mem_wdata = 64'd0; bus_b.ram_rdata = 64'd0;
    #2;
    checks++; if (bus_a.ram_en !== 1'b0) begin errors++; $display("FAIL rst_ram_en got %b exp 0", bus_a.ram_en); end
    checks++; if (bus_a.ram_we !== 1'b0) begin errors++; $display("FAIL rst_ram_we got %b exp 0", bus_a.ram_we); end
    checks++; if (bus_a.if_valid !== 1'b0 || bus_a.mem_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b%b exp 00", bus_a.if_valid, bus_a.mem_valid); end
    checks++; if (bus_a.if_rdata !== 32'd0) begin errors++; $display("FAIL rst_if_rdata got %h exp 0", bus_a.if_rdata); end
    checks++; if (bus_a.mem_rdata !== 64'd0) begin errors++; $display("FAIL rst_mem_rdata got %h exp 0", bus_a.mem_rdata); end
    checks++; if (bus_a.ram_addr !== 10'd0 || bus_a.ram_wdata !== 64'd0) begin errors++; $display("FAIL rst_ram_bus got %h/%h exp 0/0", bus_a.ram_addr, bus_a.ram_wdata); end
    checks++; if (bus_b.ram_en !== 1'b0 || bus_b.mem_valid !== 1'b0) begin errors++; $display("FAIL rst_b got %b%b exp 00", bus_b.ram_en, bus_b.mem_valid); end
    cycle(); cycle();
    reset = 1'b1;
  endtask

  task automatic test_lone_fetch();
    bus_a.if_addr = 64'h4; bus_a.ram_rdata = 64'hAAAA0013_BBBB0033; bus_a.if_req = 1'b1;
    #1;
    checks++; if (bus_a.stall_if !== 1'b1) begin errors++; $display("FAIL fetch_stall_pre got %b exp 1", bus_a.stall_if); end
    cycle();
    checks++; if (bus_a.ram_en !== 1'b1) begin errors++; $display("FAIL fetch_ram_en got %b exp 1", bus_a.ram_en); end
    checks++; if (bus_a.ram_addr !== 10'h004) begin errors++; $display("FAIL fetch_ram_addr got %h exp 004", bus_a.ram_addr); end
    checks++; if (bus_a.ram_we !== 1'b0) begin errors++; $display("FAIL fetch_ram_we got %b exp 0", bus_a.ram_we); end
    cycle();
    checks++; if (bus_a.ram_en !== 1'b0 || bus_a.if_valid !== 1'b0) begin errors++; $display("FAIL fetch_busy2 got en %b valid %b exp 0 0", bus_a.ram_en, bus_a.if_valid); end
    checks++; if (bus_a.stall_if !== 1'b1) begin errors++; $display("FAIL fetch_stall_busy got %b exp 1", bus_a.stall_if); end
    cycle();
    checks++; if (bus_a.if_valid !== 1'b1) begin errors++; $display("FAIL fetch_valid got %b exp 1", bus_a.if_valid); end
    checks++; if (bus_a.if_rdata !== 32'hAAAA0013) begin errors++; $display("FAIL fetch_rdata got %h exp AAAA0013", bus_a.if_rdata); end
    checks++; if (bus_a.stall_if !== 1'b0) begin errors++; $display("FAIL fetch_stall_valid got %b exp 0", bus_a.stall_if); end
    bus_a.if_req = 1'b0;
    cycle();
    checks++; if (bus_a.if_valid !== 1'b0 || bus_a.ram_en !== 1'b0) begin errors++; $display("FAIL fetch_after got valid %b en %b exp 0 0", bus_a.if_valid, bus_a.ram_en); end
    checks++; if (bus_a.if_rdata !== 32'hAAAA0013) begin errors++; $display("FAIL fetch_hold got %h exp AAAA0013", bus_a.if_rdata); end
  endtask

  task automatic test_store_load();
    bus_a.mem_we = 1'b1; bus_a.mem_addr = 64'h10; bus_a.mem_wdata = 64'h55; bus_a.mem_req = 1'b1;
    cycle();
    checks++; if (bus_a.ram_en !== 1'b1 || bus_a.ram_we !== 1'b1) begin errors++; $display("FAIL st_strobe got en %b we %b exp 1 1", bus_a.ram_en, bus_a.ram_we); end
    checks++; if (bus_a.ram_addr !== 10'h010 || bus_a.ram_wdata !== 64'h55) begin errors++; $display("FAIL st_bus got %h/%h exp 010/55", bus_a.ram_addr, bus_a.ram_wdata); end
    checks++; if (bus_a.stall_mem !== 1'b1) begin errors++; $display("FAIL st_stall got %b exp 1", bus_a.stall_mem); end
    cycle();
    checks++; if (bus_a.ram_we !== 1'b1 || bus_a.ram_en !== 1'b0) begin errors++; $display("FAIL st_busy2 got we %b en %b exp 1 0", bus_a.ram_we, bus_a.ram_en); end
    cycle();
    checks++; if (bus_a.mem_valid !== 1'b1 || bus_a.ram_we !== 1'b0) begin errors++; $display("FAIL st_valid got valid %b we %b exp 1 0", bus_a.mem_valid, bus_a.ram_we); end
    checks++; if (bus_a.mem_rdata !== 64'd0) begin errors++; $display("FAIL st_rdata_kept got %h exp 0", bus_a.mem_rdata); end
    bus_a.mem_we = 1'b0; bus_a.ram_rdata = 64'h55;
    cycle();
    checks++; if (bus_a.ram_en !== 1'b1 || bus_a.ram_we !== 1'b0 || bus_a.mem_valid !== 1'b0) begin errors++; $display("FAIL ld_grant got en %b we %b valid %b exp 1 0 0", bus_a.ram_en, bus_a.ram_we, bus_a.mem_valid); end
    cycle(); cycle();
    checks++; if (bus_a.mem_valid !== 1'b1 || bus_a.mem_rdata !== 64'h55) begin errors++; $display("FAIL ld_result got valid %b data %h exp 1 55", bus_a.mem_valid, bus_a.mem_rdata); end
    bus_a.mem_req = 1'b0;
    cycle();
    checks++; if (bus_a.mem_valid !== 1'b0 || bus_a.mem_rdata !== 64'h55) begin errors++; $display("FAIL ld_hold got valid %b data %h exp 0 55", bus_a.mem_valid, bus_a.mem_rdata); end
  endtask

  task automatic test_contention();
    bit exp_order [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    bit got_order [9];
    int n = 0;
    bus_a.if_addr = 64'h100; bus_a.mem_addr = 64'h200; bus_a.mem_we = 1'b0;
    bus_a.if_req = 1'b1; bus_a.mem_req = 1'b1;
    for (int c = 0; c < 80 && n < 9; c++) begin
      cycle();
      if (bus_a.ram_en === 1'b1) begin
        got_order[n] = (bus_a.ram_addr === 10'h100);
        n++;
      end
    end
    bus_a.if_req = 1'b0; bus_a.mem_req = 1'b0;
    checks++; if (n != 9) begin errors++; $display("FAIL cont_grants got %0d exp 9", n); end
    for (int i = 0; i < n; i++) begin
      checks++;
      if (got_order[i] !== exp_order[i]) begin errors++; $display("FAIL cont_order[%0d] got is_if=%b exp is_if=%b", i, got_order[i], exp_order[i]); end
    end
    for (int c = 0; c < 4; c++) cycle();
  endtask

  task automatic test_request_drop();
    int nvalid = 0;
    int nen = 0;
    bus_a.if_addr = 64'hC; bus_a.ram_rdata = 64'h11112222_33334444; bus_a.if_req = 1'b1;
    cycle();
    checks++; if (bus_a.ram_en !== 1'b1) begin errors++; $display("FAIL drop_grant got %b exp 1", bus_a.ram_en); end
    bus_a.if_req = 1'b0;
    for (int c = 0; c < 8; c++) begin
      cycle();
      if (bus_a.if_valid === 1'b1) nvalid++;
      if (bus_a.ram_en === 1'b1) nen++;
    end
    checks++; if (nvalid != 1) begin errors++; $display("FAIL drop_valid_count got %0d exp 1", nvalid); end
    checks++; if (nen != 0) begin errors++; $display("FAIL drop_regrant got %0d exp 0", nen); end
    checks++; if (bus_a.if_rdata !== 32'h11112222) begin errors++; $display("FAIL drop_rdata got %h exp 11112222", bus_a.if_rdata); end
  endtask

  task automatic test_reset_mid_access();
    int nvalid = 0;
    bus_a.mem_we = 1'b1; bus_a.mem_addr = 64'h3F8; bus_a.mem_wdata = 64'hDEADBEEF_01234567; bus_a.mem_req = 1'b1;
    cycle();
    checks++; if (bus_a.ram_en !== 1'b1) begin errors++; $display("FAIL rma_grant got %b exp 1", bus_a.ram_en); end
    cycle();
    checks++; if (bus_a.ram_we !== 1'b1) begin errors++; $display("FAIL rma_busy2 got we %b exp 1", bus_a.ram_we); end
    #2 reset = 1'b0;
    #1;
    checks++; if (bus_a.ram_we !== 1'b0 || bus_a.ram_en !== 1'b0) begin errors++; $display("FAIL rma_strobes got we %b en %b exp 0 0", bus_a.ram_we, bus_a.ram_en); end
    checks++; if (bus_a.ram_addr !== 10'd0 || bus_a.ram_wdata !== 64'd0) begin errors++; $display("FAIL rma_bus got %h/%h exp 0/0", bus_a.ram_addr, bus_a.ram_wdata); end
    checks++; if (bus_a.if_rdata !== 32'd0 || bus_a.mem_rdata !== 64'd0) begin errors++; $display("FAIL rma_rdata got %h/%h exp 0/0", bus_a.if_rdata, bus_a.mem_rdata); end
    for (int c = 0; c < 3; c++) begin
      cycle();
      if (bus_a.mem_valid !== 1'b0) nvalid++;
    end
    checks++; if (nvalid != 0) begin errors++; $display("FAIL rma_no_valid got %0d pulses exp 0", nvalid); end
    reset = 1'b1;
    cycle();
    checks++; if (bus_a.ram_en !== 1'b1 || bus_a.ram_addr !== 10'h3F8) begin errors++; $display("FAIL rma_regrant got en %b addr %h exp 1 3f8", bus_a.ram_en, bus_a.ram_addr); end
    cycle(); cycle();
    checks++; if (bus_a.mem_valid !== 1'b1) begin errors++; $display("FAIL rma_valid got %b exp 1", bus_a.mem_valid); end
    bus_a.mem_req = 1'b0;
    cycle();
  endtask

  task automatic test_back_to_back();
    int acc = 0;
    bus_b.mem_we = 1'b0; bus_b.mem_addr = 64'd0; bus_b.ram_rdata = 64'hB0; bus_b.mem_req = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      cycle();
      checks++;
      if (bus_b.ram_en !== 1'(k % 2) || bus_b.mem_valid !== 1'((k + 1) % 2)) begin
        errors++; $display("FAIL b2b_phase k=%0d got en %b valid %b exp %0d %0d", k, bus_b.ram_en, bus_b.mem_valid, k % 2, (k + 1) % 2);
      end
      if (k % 2 == 1) begin
        checks++;
        if (bus_b.ram_addr !== 10'(8 * acc)) begin errors++; $display("FAIL b2b_addr k=%0d got %h exp %h", k, bus_b.ram_addr, 10'(8 * acc)); end
      end else begin
        checks++;
        if (bus_b.mem_rdata !== 64'hB0 + 64'(acc)) begin errors++; $display("FAIL b2b_rdata k=%0d got %h exp %h", k, bus_b.mem_rdata, 64'hB0 + 64'(acc)); end
        acc++;
        bus_b.mem_addr = 64'(8 * acc); bus_b.ram_rdata = 64'hB0 + 64'(acc);
      end
    end
    bus_b.mem_req = 1'b0;
    cycle();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      cycle();
      checks++; if (bus_a.if_valid !== exp_if_valid) begin errors++; $display("FAIL rnd_if_valid c=%0d got %b exp %b", c, bus_a.if_valid, exp_if_valid); end
      checks++; if (bus_a.mem_valid !== exp_mem_valid) begin errors++; $display("FAIL rnd_mem_valid c=%0d got %b exp %b", c, bus_a.mem_valid, exp_mem_valid); end
      checks++; if (bus_a.ram_en !== exp_ram_en) begin errors++; $display("FAIL rnd_ram_en c=%0d got %b exp %b", c, bus_a.ram_en, exp_ram_en); end
      checks++; if (bus_a.ram_we !== exp_ram_we) begin errors++; $display("FAIL rnd_ram_we c=%0d got %b exp %b", c, bus_a.ram_we, exp_ram_we); end
      checks++; if (bus_a.if_rdata !== exp_if_rdata) begin errors++; $display("FAIL rnd_if_rdata c=%0d got %h exp %h", c, bus_a.if_rdata, exp_if_rdata); end
      checks++; if (bus_a.mem_rdata !== exp_mem_rdata) begin errors++; $display("FAIL rnd_mem_rdata c=%0d got %h exp %h", c, bus_a.mem_rdata, exp_mem_rdata); end
      checks++; if (bus_a.stall_if !== (bus_a.if_req && !exp_if_valid)) begin errors++; $display("FAIL rnd_stall_if c=%0d got %b exp %b", c, bus_a.stall_if, bus_a.if_req && !exp_if_valid); end
      checks++; if (bus_a.stall_mem !== (bus_a.mem_req && !exp_mem_valid)) begin errors++; $display("FAIL rnd_stall_mem c=%0d got %b exp %b", c, bus_a.stall_mem, bus_a.mem_req && !exp_mem_valid); end
      if (m_active) begin
        checks++; if (bus_a.ram_addr !== m_addr) begin errors++; $display("FAIL rnd_ram_addr c=%0d got %h exp %h", c, bus_a.ram_addr, m_addr); end
        if (!m_is_if) begin
          checks++; if (bus_a.ram_wdata !== m_wdata) begin errors++; $display("FAIL rnd_ram_wdata c=%0d got %h exp %h", c, bus_a.ram_wdata, m_wdata); end
        end
      end
      if (!bus_a.if_req || exp_if_valid) begin
        bus_a.if_req  = ($urandom_range(0, 2) != 0);
        bus_a.if_addr = {$urandom, $urandom};
      end
      if (!bus_a.mem_req || exp_mem_valid) begin
        bus_a.mem_req   = ($urandom_range(0, 2) != 0);
        bus_a.mem_we    = 1'($urandom_range(0, 1));
        bus_a.mem_addr  = {$urandom, $urandom};
        bus_a.mem_wdata = {$urandom, $urandom};
      end
      bus_a.ram_rdata = {$urandom, $urandom};
    end
  endtask

  initial begin
    test_reset();
    test_lone_fetch();
    test_store_load();
    test_contention();
    test_request_drop();
    test_reset_mid_access();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog sim time exceeded bound");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter LATENCY, default 2: number of cycles the RAM port stays busy per access; legal range 1..7.
REQ-002 Parameter STARVE_MAX, default 3: number of consecutive MEM wins allowed while IF is waiting.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 if_req  input  1  fetch request; held with if_addr stable until if_valid.
REQ-006 if_addr  input  64  fetch byte address.
REQ-007 if_rdata  output  32  fetched instruction, registered.
REQ-008 if_valid  output  1  one-cycle pulse; fetch complete.
REQ-009 mem_req  input  1  load/store request; held with mem_we/mem_addr/mem_wdata stable until mem_valid.
REQ-010 mem_we  input  1  1 = store, 0 = load.
REQ-011 mem_addr  input  64  load/store byte address.
REQ-012 mem_wdata  input  64  store data.
REQ-013 mem_rdata  output  64  load data, registered.
REQ-014 mem_valid  output  1  one-cycle pulse; load/store complete.
REQ-015 ram_en  output  1  RAM access strobe.
REQ-016 ram_we  output  1  RAM write enable.
REQ-017 ram_addr  output  10  RAM byte address.
REQ-018 ram_wdata  output  64  RAM write data.
REQ-019 ram_rdata  input  64  RAM read data; valid by the final BUSY cycle.
REQ-020 stall_if  output  1  equals if_req AND NOT if_valid, combinational.
REQ-021 stall_mem  output  1  equals mem_req AND NOT mem_valid, combinational.

Function
REQ-022 The FSM SHALL have three states: IDLE, BUSY_IF and BUSY_MEM.
REQ-023 In IDLE at a rising edge, mem_req alone SHALL move the FSM to BUSY_MEM, and if_req alone SHALL move it to BUSY_IF.
REQ-024 In IDLE, when mem_req and if_req are both high, MEM SHALL win unless starve_cnt equals STARVE_MAX, in which case IF SHALL win.
REQ-025 starve_cnt SHALL increment, saturating at STARVE_MAX, on each MEM grant made while if_req is high.
REQ-026 starve_cnt SHALL clear on each IF grant.
REQ-027 On a grant edge the block SHALL latch addr[9:0], we (0 for IF) and wdata into internal registers, and load busy_cnt with LATENCY-1.
REQ-028 ram_addr, ram_we and ram_wdata SHALL be driven from the latched registers for the whole BUSY period.
REQ-029 ram_en SHALL be high only during the first BUSY cycle, and ram_we SHALL be 0 outside BUSY_MEM.
REQ-030 In BUSY, busy_cnt SHALL decrement each edge.
REQ-031 At the edge where busy_cnt equals 0, the FSM SHALL return to IDLE and capture read data.
REQ-032 For BUSY_IF, captured read data SHALL be if_rdata = latched addr[2] ? ram_rdata[63:32] : ram_rdata[31:0].
REQ-033 For a BUSY_MEM load, captured read data SHALL be mem_rdata = ram_rdata.
REQ-034 if_valid or mem_valid SHALL be high for exactly that following IDLE cycle.
REQ-035 A store SHALL pulse mem_valid and leave mem_rdata unchanged.
REQ-036 Latency from the grant edge to the valid cycle SHALL be LATENCY cycles, and the next grant SHALL be made no earlier than the edge ending the valid cycle (one access per LATENCY+1 cycles).
REQ-037 New requests SHALL NOT be sampled in BUSY.
REQ-038 Deassertion of a request during BUSY SHALL NOT abort the access, and the valid pulse SHALL still be issued.
REQ-039 The unserved requester SHALL see its stall signal stay high throughout.
REQ-040 if_rdata and mem_rdata SHALL hold their value between captures.

Reset
REQ-041 While reset=0, regardless of clk, the FSM SHALL be IDLE and starve_cnt and busy_cnt SHALL be 0.
REQ-042 While reset=0, ram_en, ram_we, if_valid and mem_valid SHALL be 0, and if_rdata, mem_rdata, ram_addr and ram_wdata SHALL be 0.
REQ-043 Reset asserted mid-access SHALL abort the access with no valid pulse, and the first grant SHALL occur at the first rising edge after reset deasserts with a request present.

Verification
REQ-044 Lone fetch: LATENCY=2, if_req=1, if_addr=0x4, ram_rdata=0xAAAA0013_BBBB0033 -> ram_en for 1 cycle with ram_addr=0x004; if_valid 2 cycles after grant; if_rdata=0xAAAA0013; stall_if high until valid.
REQ-045 Store then load: mem_we=1, addr=0x10, wdata=0x55 -> ram_we=1, ram_wdata=0x55, mem_valid pulse, mem_rdata unchanged; then load with ram_rdata=0x55 -> mem_rdata=0x55.
REQ-046 Contention: if_req and mem_req held continuously, STARVE_MAX=3 -> grant order MEM, MEM, MEM, IF, then MEM; starve_cnt clears after the IF grant.
REQ-047 Request drop: if_req deasserted in the cycle after grant -> access completes, if_valid pulses once, no further grant.
REQ-048 Reset mid-access: reset=0 in the second BUSY_MEM cycle -> outputs 0 immediately with no clk edge, no mem_valid; after release with mem_req=1, a fresh grant on the next edge.
REQ-049 LATENCY=1 back-to-back: mem_req held with a new address after each valid -> valid every 2nd cycle, and ram_en is never high during a valid cycle.
